kgp_multicycle_ctrl: RTL and testbench
======================================

Name: kgp_multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the KGP RISC datapath. It replaces the single-cycle combinational opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with a variable-latency memory port (mem_req/mem_ready).
- Keeps an architectural flag register (Z, C, S, V) and resolves all conditional branches, call and ret internally.
- Sits between the instruction register/memory interface and the datapath muxes, ALU and register file.

Parameters:
- OPCODE_W, 6, opcode field width. Opcodes above 6'b011111 are illegal.
- ALU_OP_W, 3, ALU operation code width.
- TIMEOUT_CYC, 16, cycles allowed for mem_ready before a trap. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  OPCODE_W  opcode field of the instruction register. Valid from DECODE onward.
- mem_ready  in  1  memory completes the current request this cycle.
- alu_zero, alu_carry, alu_sign, alu_ovf  in  1 each  ALU result flags. Valid in EXEC.
- mem_req  out  1  memory access request. Held until mem_ready.
- mem_we  out  1  write qualifier for mem_req.
- ir_write  out  1  load IR from memory data.
- pc_write  out  1  update PC.
- pc_src  out  2  0 = PC+1, 1 = immediate target, 2 = register target (br), 3 = return-stack top.
- alu_src  out  1  0 = register operand, 1 = immediate operand.
- alu_op  out  ALU_OP_W  ALU operation: 000 add, 001 comp, 010 and, 011 xor, 100 shl, 101 shr, 110 sra, 111 none.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback source: 1 = memory data.
- rs_push, rs_pop  out  1 each  return-stack push/pop strobes, one cycle wide.
- flags_q  out  4  {V,S,C,Z} flag register.
- trap  out  1  sticky illegal-opcode or timeout indication.
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Encoding is in the package.
- Reset (asynchronous):
  - state = IDLE, op_q = 0, flags_q = 0, trap = 0, trap_cause = 0.
  - All strobes 0. alu_op = 111.
- IDLE -> FETCH unconditionally on the next clock.
- FETCH:
  - mem_req = 1, mem_we = 0.
  - Stays in FETCH until mem_ready.
  - On the mem_ready cycle: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
- DECODE:
  - op_q <= opcode.
  - Opcode not in the legal set {000000-000101, 001000, 001001, 001100-001110, 010000-010010, 010100-011111}: go to TRAP, trap_cause = 01.
- EXEC: outputs are decoded from op_q.
  - add/comp/and/xor: alu_src = 0, alu_op per opcode.
  - addi/compi: alu_src = 1.
  - Shifts: shll/shrl/shra use alu_src = 1; shllv/shrlv/shrav use alu_src = 0. alu_op = 100/101/110.
  - ALU and shift ops latch flags_q <= {alu_ovf, alu_sign, alu_carry, alu_zero} at the end of EXEC, then go to WB.
  - lw/sw: alu_src = 1, alu_op = 000, then go to MEM. Flags unchanged.
  - Branches:
    - b: always taken.
    - bz/bnz: test Z. bcy/bncy: test C. bs/bns: test S. bv/bnv: test V.
    - Conditions use flags_q, i.e. flags from the previous ALU instruction, not the live ALU inputs.
    - Taken: pc_write = 1, pc_src = 1. Not taken: no PC write.
    - br: pc_write = 1, pc_src = 2, alu_op = 000.
    - All branches go to FETCH.
  - call: rs_push = 1, pc_write = 1, pc_src = 1, then FETCH.
  - ret: rs_pop = 1, pc_write = 1, pc_src = 3, then FETCH.
- MEM:
  - mem_req = 1, mem_we = 1 for sw.
  - Address operands are held: alu_src = 1, alu_op = 000.
  - Waits for mem_ready. Then lw -> WB, sw -> FETCH.
- WB:
  - reg_write = 1. mem_to_reg = 1 for lw.
  - Then FETCH.
- Latency with 1-cycle mem_ready:
  - ALU ops: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branches, call, ret: 3 cycles.
- mem_ready outside FETCH/MEM is ignored.
- mem_req is never deasserted before mem_ready.
- TRAP:
  - All strobes 0. trap = 1.
  - Held until rst.
- Reset mid-access: mem_req drops immediately (asynchronous). No partial register or PC write follows.

Optional Feature:
- Macro: KGP_MEM_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entry to FETCH/MEM and counts each cycle without mem_ready.
  - On reaching TIMEOUT_CYC: go to TRAP, trap_cause = 10.
- Undefined:
  - No counter. Waits indefinitely.
  - trap_cause[1] is constant 0.

Decomposition:
- Package kgp_pkg holds:
  - opcode constants.
  - ALU op constants, including none = 3'b111.
  - state enum.
  - pc_src encodings.
  - trap_cause codes.
- One sub-module, kgp_branch_resolve: combinational; op_q + flags_q -> taken.

Test Plan:
- Reset, then mem_ready = 1 on cycle 2, opcode = 000000 (add):
  - ir_write pulses.
  - reg_write = 1 exactly in cycle 4 after FETCH entry.
  - alu_op = 000, alu_src = 0.
- addi giving alu_zero = 1, then bz:
  - pc_write = 1, pc_src = 1 in bz EXEC.
- Repeat with alu_zero = 0:
  - bz EXEC shows no pc_write.
  - bnz EXEC shows pc_write = 1.
- lw with mem_ready delayed 3 cycles in MEM:
  - mem_req held high 4 cycles.
  - Then WB with reg_write = 1, mem_to_reg = 1.
- sw:
  - mem_we = 1 only in MEM.
  - No reg_write.
  - Returns to FETCH.
- call then ret:
  - rs_push pulse with pc_src = 1.
  - Later rs_pop pulse with pc_src = 3.
  - flags_q unchanged.
- Opcode 100000:
  - TRAP with trap_cause = 01, all strobes 0.
  - rst asserted mid-TRAP returns to IDLE.
- With KGP_MEM_TIMEOUT_EN and mem_ready held 0:
  - trap_cause = 10 after 16 FETCH cycles.
- Without the macro: still in FETCH after 100 cycles.

Source files
------------

// File: rtl/kgp_pkg.sv
// Shared encodings for the KGP multi-cycle control sequencer.
// Holds opcodes, ALU ops, FSM states, PC source selects and trap causes.
package kgp_pkg;

  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPC_W-1:0] OP_COMP  = 6'b000001;
  localparam logic [OPC_W-1:0] OP_AND   = 6'b000010;
  localparam logic [OPC_W-1:0] OP_XOR   = 6'b000011;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b000100;
  localparam logic [OPC_W-1:0] OP_COMPI = 6'b000101;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b001000;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b001001;
  localparam logic [OPC_W-1:0] OP_SHLL  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_SHRL  = 6'b001101;
  localparam logic [OPC_W-1:0] OP_SHRA  = 6'b001110;
  localparam logic [OPC_W-1:0] OP_SHLLV = 6'b010000;
  localparam logic [OPC_W-1:0] OP_SHRLV = 6'b010001;
  localparam logic [OPC_W-1:0] OP_SHRAV = 6'b010010;
  localparam logic [OPC_W-1:0] OP_B     = 6'b010100;
  localparam logic [OPC_W-1:0] OP_BR    = 6'b010101;
  localparam logic [OPC_W-1:0] OP_BZ    = 6'b010110;
  localparam logic [OPC_W-1:0] OP_BNZ   = 6'b010111;
  localparam logic [OPC_W-1:0] OP_BCY   = 6'b011000;
  localparam logic [OPC_W-1:0] OP_BNCY  = 6'b011001;
  localparam logic [OPC_W-1:0] OP_BS    = 6'b011010;
  localparam logic [OPC_W-1:0] OP_BNS   = 6'b011011;
  localparam logic [OPC_W-1:0] OP_BV    = 6'b011100;
  localparam logic [OPC_W-1:0] OP_BNV   = 6'b011101;
  localparam logic [OPC_W-1:0] OP_CALL  = 6'b011110;
  localparam logic [OPC_W-1:0] OP_RET   = 6'b011111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_COMP = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SHL  = 3'b100;
  localparam logic [2:0] ALU_SHR  = 3'b101;
  localparam logic [2:0] ALU_SRA  = 3'b110;
  localparam logic [2:0] ALU_NONE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_IMM = 2'd1;
  localparam logic [1:0] PC_SRC_REG = 2'd2;
  localparam logic [1:0] PC_SRC_RS  = 2'd3;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  function automatic logic opcode_legal(input logic [OPC_W-1:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_COMP, OP_AND, OP_XOR, OP_ADDI, OP_COMPI,
      OP_LW, OP_SW, OP_SHLL, OP_SHRL, OP_SHRA,
      OP_SHLLV, OP_SHRLV, OP_SHRAV,
      OP_B, OP_BR, OP_BZ, OP_BNZ, OP_BCY, OP_BNCY,
      OP_BS, OP_BNS, OP_BV, OP_BNV, OP_CALL, OP_RET: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [OPC_W-1:0] op);
    logic [2:0] aop;
    case (op)
      OP_ADD, OP_ADDI:    aop = ALU_ADD;
      OP_COMP, OP_COMPI:  aop = ALU_COMP;
      OP_AND:             aop = ALU_AND;
      OP_XOR:             aop = ALU_XOR;
      OP_SHLL, OP_SHLLV:  aop = ALU_SHL;
      OP_SHRL, OP_SHRLV:  aop = ALU_SHR;
      OP_SHRA, OP_SHRAV:  aop = ALU_SRA;
      default:            aop = ALU_NONE;
    endcase
    return aop;
  endfunction

endpackage

// File: rtl/kgp_branch_resolve.sv
// Branch condition evaluation: latched opcode plus the architectural flags
// {V,S,C,Z} decide whether a PC-relative branch is taken.
module kgp_branch_resolve import kgp_pkg::*; (
  input  logic [OPC_W-1:0] op_q,
  input  logic [3:0]       flags_q,
  output logic             taken
);

  // Conditions read the registered flags, never the live ALU outputs
  always_comb begin
    taken = 1'b0;
    case (op_q)
      OP_B:    taken = 1'b1;
      OP_BZ:   taken = flags_q[0];
      OP_BNZ:  taken = ~flags_q[0];
      OP_BCY:  taken = flags_q[1];
      OP_BNCY: taken = ~flags_q[1];
      OP_BS:   taken = flags_q[2];
      OP_BNS:  taken = ~flags_q[2];
      OP_BV:   taken = flags_q[3];
      OP_BNV:  taken = ~flags_q[3];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/kgp_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the KGP datapath.
// Define KGP_MEM_TIMEOUT_EN to trap when mem_ready stays low for TIMEOUT_CYC cycles.
module kgp_multicycle_ctrl import kgp_pkg::*; #(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned ALU_OP_W    = 3,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                alu_zero,
  input  logic                alu_carry,
  input  logic                alu_sign,
  input  logic                alu_ovf,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                rs_push,
  output logic                rs_pop,
  output logic [3:0]          flags_q,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [3:0]          flags_d;
  logic                trap_q, trap_d;
  logic [1:0]          cause_q, cause_d;
  logic                taken_s;
  logic                wait_expired_s;

  kgp_branch_resolve u_branch_resolve (
    .op_q    (op_q),
    .flags_q (flags_q),
    .taken   (taken_s)
  );

`ifdef KGP_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Counts consecutive stalled cycles; any exit from FETCH/MEM leaves it at zero
  always_comb begin
    wait_cnt_d = {CNT_W{1'b0}};
    if (((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = {CNT_W{1'b0}};
    end
  end

  assign wait_expired_s = (wait_cnt_d == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= {CNT_W{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic timeout_cyc_unused_s;
  assign timeout_cyc_unused_s = (TIMEOUT_CYC != 32'd0);
  assign wait_expired_s       = 1'b0;
`endif

  // State, latched opcode, flags and sticky trap registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= {OPCODE_W{1'b0}};
      flags_q <= 4'b0000;
      trap_q  <= 1'b0;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      flags_q <= flags_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;

  // Next-state and control decode; outputs are combinational from state_q so
  // an asynchronous reset drops every strobe, including mem_req, at once.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    flags_d    = flags_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_INC;
    alu_src    = 1'b0;
    alu_op     = ALU_NONE;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    rs_push    = 1'b0;
    rs_pop     = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_INC;
          state_d  = ST_DECODE;
        end else if (wait_expired_s) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = TRAP_TIMEOUT;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_DECODE: begin
        op_d = opcode;
        if (opcode_legal(opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = TRAP_ILLEGAL;
        end
      end

      ST_EXEC: begin
        case (op_q)
          OP_ADD, OP_COMP, OP_AND, OP_XOR, OP_SHLLV, OP_SHRLV, OP_SHRAV: begin
            alu_src = 1'b0;
            alu_op  = alu_op_of(op_q);
            flags_d = {alu_ovf, alu_sign, alu_carry, alu_zero};
            state_d = ST_WB;
          end
          OP_ADDI, OP_COMPI, OP_SHLL, OP_SHRL, OP_SHRA: begin
            alu_src = 1'b1;
            alu_op  = alu_op_of(op_q);
            flags_d = {alu_ovf, alu_sign, alu_carry, alu_zero};
            state_d = ST_WB;
          end
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
            state_d = ST_MEM;
          end
          OP_B, OP_BZ, OP_BNZ, OP_BCY, OP_BNCY, OP_BS, OP_BNS, OP_BV, OP_BNV: begin
            if (taken_s) begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_IMM;
            end else begin
              pc_write = 1'b0;
            end
            state_d = ST_FETCH;
          end
          OP_BR: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_REG;
            alu_op   = ALU_ADD;
            state_d  = ST_FETCH;
          end
          OP_CALL: begin
            rs_push  = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_IMM;
            state_d  = ST_FETCH;
          end
          OP_RET: begin
            rs_pop   = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_RS;
            state_d  = ST_FETCH;
          end
          default: begin
            state_d = ST_TRAP;
            trap_d  = 1'b1;
            cause_d = TRAP_ILLEGAL;
          end
        endcase
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_SW);
        alu_src = 1'b1;
        alu_op  = ALU_ADD;
        if (mem_ready) begin
          state_d = (op_q == OP_SW) ? ST_FETCH : ST_WB;
        end else if (wait_expired_s) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = TRAP_TIMEOUT;
        end else begin
          state_d = ST_MEM;
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LW);
        state_d    = ST_FETCH;
      end

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// Randomised instruction-level bench for kgp_multicycle_ctrl with a per-instruction
// reference model of the expected control sequence and flag register.
module tb_kgp_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready, alu_zero, alu_carry, alu_sign, alu_ovf;
  logic       mem_req, mem_we, ir_write, pc_write, alu_src, reg_write, mem_to_reg;
  logic       rs_push, rs_pop, trap;
  logic [1:0] pc_src, trap_cause;
  logic [2:0] alu_op;
  logic [3:0] flags_q;

  kgp_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_ovf(alu_ovf),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .rs_push(rs_push), .rs_pop(rs_pop),
    .flags_q(flags_q), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  localparam int B_MREQ = 13, B_MWE = 12, B_IRW = 11, B_PCW = 10, B_PCS = 8;
  localparam int B_ASRC = 7, B_AOP = 4, B_RW = 3, B_M2R = 2, B_PUSH = 1, B_POP = 0;
  localparam logic [13:0] M_STROBE = 14'b11110000001011;
  localparam logic [13:0] M_PCS    = 14'b00001100000000;
  localparam logic [13:0] M_ALU    = 14'b00000011110000;
  localparam logic [13:0] M_AOP    = 14'b00000001110000;
  localparam logic [13:0] M_M2R    = 14'b00000000000100;

  localparam int K_ALU_R = 0, K_ALU_I = 1, K_LW = 2, K_SW = 3, K_B = 4;
  localparam int K_BCOND = 5, K_BR = 6, K_CALL = 7, K_RET = 8, K_ILL = 9;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] m_flags  = 4'd0;
  logic [5:0] legal_ops [24];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] ctl_now();
    return {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src, alu_op,
            reg_write, mem_to_reg, rs_push, rs_pop};
  endfunction

  task automatic ctl_check(input string tag, input logic [13:0] e, input logic [13:0] m);
    check_eq(tag, 32'(ctl_now() & m), 32'(e & m));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    {alu_ovf, alu_sign, alu_carry, alu_zero} = 4'($urandom);
  endtask

  // Instruction classes from the opcode map; conditional branches come in
  // (true, false) pairs over Z, C, S, V starting at 010110.
  task automatic ref_decode(input logic [5:0] op, output int kind, output logic [2:0] aop,
                            output int fidx, output logic fpol);
    int o;
    o = int'(op);
    kind = K_ILL; aop = 3'b111; fidx = 0; fpol = 1'b1;
    case (o)
      0, 1, 2, 3:   begin kind = K_ALU_R; aop = 3'(o); end
      4, 5:         begin kind = K_ALU_I; aop = 3'(o - 4); end
      8:            kind = K_LW;
      9:            kind = K_SW;
      12, 13, 14:   begin kind = K_ALU_I; aop = 3'(o - 8); end
      16, 17, 18:   begin kind = K_ALU_R; aop = 3'(o - 12); end
      20:           kind = K_B;
      21:           kind = K_BR;
      22, 23, 24, 25, 26, 27, 28, 29: begin
        kind = K_BCOND; fidx = (o - 22) / 2; fpol = ((o - 22) % 2 == 0);
      end
      30:           kind = K_CALL;
      31:           kind = K_RET;
      default:      kind = K_ILL;
    endcase
  endtask

  // Walks one instruction from its first FETCH cycle; returns at the TRAP cycle for illegal ops.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic [3:0] fin);
    int kind, fidx;
    logic [2:0] aop;
    logic fpol, taken;
    logic [13:0] e, m;
    ref_decode(op, kind, aop, fidx, fpol);
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0; noise();
      @(negedge clk);
      e = 14'd0; e[B_MREQ] = 1'b1;
      ctl_check("fetch_wait", e, M_STROBE);
      tick();
    end
    mem_ready = 1'b1; noise();
    @(negedge clk);
    e = 14'd0; e[B_MREQ] = 1'b1; e[B_IRW] = 1'b1; e[B_PCW] = 1'b1; e[B_PCS +: 2] = 2'd0;
    ctl_check("fetch_done", e, M_STROBE | M_PCS);
    tick();
    mem_ready = 1'($urandom); opcode = op; noise();
    @(negedge clk);
    ctl_check("decode", 14'd0, M_STROBE);
    check_eq("flags_hold", 32'(flags_q), 32'(m_flags));
    tick();
    if (kind == K_ILL) begin
      mem_ready = 1'($urandom); opcode = 6'($urandom);
      @(negedge clk);
      ctl_check("trap_strobes", 14'd0, M_STROBE);
      check_eq("trap_flag", 32'(trap), 32'd1);
      check_eq("trap_cause_ill", 32'(trap_cause), 32'd1);
      return;
    end
    mem_ready = 1'($urandom); opcode = 6'($urandom);
    {alu_ovf, alu_sign, alu_carry, alu_zero} = fin;
    @(negedge clk);
    e = 14'd0; m = M_STROBE;
    case (kind)
      K_ALU_R, K_ALU_I: begin
        e[B_ASRC] = (kind == K_ALU_I); e[B_AOP +: 3] = aop; m = M_STROBE | M_ALU;
      end
      K_LW, K_SW: begin
        e[B_ASRC] = 1'b1; e[B_AOP +: 3] = 3'b000; m = M_STROBE | M_ALU;
      end
      K_B, K_BCOND: begin
        taken = (kind == K_B) ? 1'b1 : (m_flags[fidx] == fpol);
        e[B_PCW] = taken; e[B_PCS +: 2] = 2'd1;
        m = taken ? (M_STROBE | M_PCS) : M_STROBE;
      end
      K_BR: begin
        e[B_PCW] = 1'b1; e[B_PCS +: 2] = 2'd2; e[B_AOP +: 3] = 3'b000;
        m = M_STROBE | M_PCS | M_AOP;
      end
      K_CALL: begin
        e[B_PUSH] = 1'b1; e[B_PCW] = 1'b1; e[B_PCS +: 2] = 2'd1; m = M_STROBE | M_PCS;
      end
      default: begin
        e[B_POP] = 1'b1; e[B_PCW] = 1'b1; e[B_PCS +: 2] = 2'd3; m = M_STROBE | M_PCS;
      end
    endcase
    ctl_check($sformatf("exec_op%0d", op), e, m);
    tick();
    if (kind == K_ALU_R || kind == K_ALU_I) m_flags = fin;
    if (kind == K_LW || kind == K_SW) begin
      for (int i = 0; i <= mw; i++) begin
        mem_ready = (i == mw); noise();
        @(negedge clk);
        e = 14'd0; e[B_MREQ] = 1'b1; e[B_MWE] = (kind == K_SW);
        e[B_ASRC] = 1'b1; e[B_AOP +: 3] = 3'b000;
        ctl_check((i == mw) ? "mem_done" : "mem_wait", e, M_STROBE | M_ALU);
        tick();
      end
    end
    if (kind == K_ALU_R || kind == K_ALU_I || kind == K_LW) begin
      mem_ready = 1'($urandom); noise();
      @(negedge clk);
      e = 14'd0; e[B_RW] = 1'b1; e[B_M2R] = (kind == K_LW);
      ctl_check("wb", e, M_STROBE | M_M2R);
      check_eq("flags_latched", 32'(flags_q), 32'(m_flags));
      tick();
    end
  endtask

  initial begin
    logic [5:0] ill_ops [4];
    logic [13:0] e;
    legal_ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd12, 6'd13, 6'd14,
                  6'd16, 6'd17, 6'd18, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
                  6'd26, 6'd27, 6'd28, 6'd29};
    rst = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
    {alu_ovf, alu_sign, alu_carry, alu_zero} = 4'd0;
    @(negedge clk);
    e = 14'd0; e[B_AOP +: 3] = 3'b111;
    ctl_check("reset_ctl", e, M_STROBE | M_AOP);
    check_eq("reset_flags", 32'(flags_q), 32'd0);
    check_eq("reset_trap", 32'(trap), 32'd0);
    check_eq("reset_cause", 32'(trap_cause), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    ctl_check("idle", 14'd0, M_STROBE);
    tick();

    // Directed sequence
    run_instr(6'd0,  0, 0, 4'b0000);
    run_instr(6'd4,  0, 0, 4'b0001);
    run_instr(6'd22, 0, 0, 4'b0000);
    run_instr(6'd4,  0, 0, 4'b1110);
    run_instr(6'd22, 0, 0, 4'b0000);
    run_instr(6'd23, 0, 0, 4'b0000);
    run_instr(6'd8,  0, 3, 4'b0000);
    run_instr(6'd9,  1, 0, 4'b0000);
    run_instr(6'd30, 0, 0, 4'b0000);
    run_instr(6'd31, 2, 0, 4'b0101);

    // Random legal instruction stream; call/ret added to the legal pool
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      int sel;
      sel = int'($urandom_range(0, 25));
      op  = (sel < 24) ? legal_ops[sel] : ((sel == 24) ? 6'd30 : 6'd31);
      run_instr(op, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                int'($urandom_range(0, 3)), 4'($urandom));
    end

    // Reset in the middle of a fetch
    mem_ready = 1'b0;
    #2;
    check_eq("pre_rst_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    ctl_check("rst_mid_access", 14'd0, M_STROBE);
    tick();
    rst = 1'b0; m_flags = 4'd0;
    @(negedge clk);
    ctl_check("idle_after_rst", 14'd0, M_STROBE);
    check_eq("flags_after_rst", 32'(flags_q), 32'd0);
    tick();

    // Illegal opcodes: trap, hold, then reset out of TRAP
    ill_ops = '{6'b100000, 6'b000110, 6'b001111, 6'(32 + $urandom_range(0, 31))};
    for (int k = 0; k < 4; k++) begin
      run_instr(ill_ops[k], int'($urandom_range(0, 2)), 0, 4'd0);
      tick();
      for (int j = 0; j < 4; j++) begin
        mem_ready = 1'($urandom); noise();
        @(negedge clk);
        ctl_check("trap_hold", 14'd0, M_STROBE);
        check_eq("trap_sticky", 32'({trap, trap_cause}), 32'b101);
        tick();
      end
      rst = 1'b1;
      #1;
      check_eq("trap_cleared", 32'({trap, trap_cause}), 32'd0);
      ctl_check("trap_rst_strobes", 14'd0, M_STROBE);
      tick();
      rst = 1'b0; m_flags = 4'd0;
      @(negedge clk);
      ctl_check("idle_after_trap", 14'd0, M_STROBE);
      tick();
    end

    // Memory never answers in FETCH
    mem_ready = 1'b0;
`ifdef KGP_MEM_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 16) begin
        check_eq("timeout_last_req", 32'(mem_req), 32'd1);
        check_eq("timeout_not_yet", 32'(trap), 32'd0);
      end
      tick();
    end
    @(negedge clk);
    check_eq("timeout_trap", 32'({trap, trap_cause}), 32'b110);
    ctl_check("timeout_strobes", 14'd0, M_STROBE);
`else
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 100) begin
        e = 14'd0; e[B_MREQ] = 1'b1;
        ctl_check("hang_still_fetch", e, M_STROBE);
        check_eq("hang_no_trap", 32'({trap, trap_cause}), 32'd0);
      end
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq("hang_then_ready", 32'({ir_write, pc_write}), 32'b11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
